extend: RTL and testbench
=========================

Name: extend

Overview:
- Immediate extender for the MIPS datapath. Widens a 16-bit instruction immediate to 32 bits, either sign-extended or zero-extended, under a one-bit control from the main decoder.
- Primary result is combinational so it feeds the ALU B-mux in the same cycle.
- A registered copy is also provided for pipelined datapaths; it is the only clocked state.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; must satisfy OUT_W > IN_W.

Ports:
- clk, input, 1, rising-edge clock; used only by the registered copy.
- reset, input, 1, synchronous, active-high; clears the registered outputs only.
- out, output, OUT_W, combinational extended value.
- in, input, IN_W, raw immediate field.
- signal, input, 1, 1 = sign-extend, 0 = zero-extend.
- out_q, output, OUT_W, registered copy of out.
- neg_q, output, 1, registered flag, 1 when the captured value was sign-extended from a negative immediate.
- Declaration order is out, in, signal, clk, reset, out_q, neg_q, so the first three positions stay compatible with existing positional instantiations.

Behaviour:
- Combinational path:
  - out[IN_W-1:0] = in always.
  - out[OUT_W-1:IN_W] = {(OUT_W-IN_W){in[IN_W-1] & signal}}.
  - Zero latency; no dependence on clk or reset.
  - out is valid even while reset is asserted or clk is stopped.
- signal = 0: upper bits are 0 regardless of in[15].
- signal = 1, in[15] = 0: upper bits are 0.
- signal = 1, in[15] = 1: upper bits are all 1.
- X or Z on signal must not be optimised away; simulation propagates X into the upper bits only.
- Registered path, on each rising clk edge:
  - reset = 1: out_q <= 0, neg_q <= 0.
  - Otherwise: out_q <= out; neg_q <= signal & in[IN_W-1].
- Latency for out_q and neg_q is 1 cycle; there is no enable and no handshake.
- Reset asserted mid-stream clears out_q and neg_q at the next edge. The first valid capture is at the first edge after reset deasserts.
- Reset has priority over data capture.
- No other state and no FSM.

Decomposition:
- Shared package holds:
  - IMM_W = 16 and WORD_W = 32;
  - the extend-mode constants EXT_ZERO = 1'b0 and EXT_SIGN = 1'b1, which the control decoder also uses.
- No sub-module. The replication logic and the one register stage are kept inline.

Test Plan:
- in=16'h83FF, signal=1 -> out=32'hFFFF83FF; next cycle out_q=32'hFFFF83FF, neg_q=1.
- in=16'h83FF, signal=0 -> out=32'h000083FF; neg_q=0.
- in=16'h03FF, signal=1 -> out=32'h000003FF; neg_q=0.
- in=16'h03FF, signal=0 -> out=32'h000003FF.
- Boundary values:
  - in=16'h8000, signal=1 -> 32'hFFFF8000;
  - in=16'h7FFF, signal=1 -> 32'h00007FFF;
  - in=16'hFFFF, signal=0 -> 32'h0000FFFF.
- Reset checks:
  - Assert reset with out_q nonzero -> out_q=0 and neg_q=0 after one edge, while out still tracks in/signal combinationally.
  - Deassert reset -> capture resumes on the next edge.

Source files
------------

// File: rtl/extend_pkg.sv
// Shared widths and extend-mode encodings for the immediate extender and the
// main control decoder that drives its mode select.
package extend_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = 32;

    // Mode select values placed on the extender's signal input.
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage : extend_pkg

// File: rtl/extend_if.sv
// Bundle of the extender's data-side signals; the decoder/datapath side drives
// the immediate and mode, the extender side returns the widened values.
interface extend_if
    import extend_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = WORD_W
);

    logic [IN_W-1:0]  in;
    logic             signal;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] out_q;
    logic             neg_q;

    modport master (
        output in,
        output signal,
        input  out,
        input  out_q,
        input  neg_q
    );

    modport slave (
        input  in,
        input  signal,
        output out,
        output out_q,
        output neg_q
    );

endinterface : extend_if

// File: rtl/extend.sv
// Immediate extender: combinational sign/zero extension for the ALU B-mux plus
// a single registered copy (and negative flag) for pipelined datapaths.
module extend
    import extend_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = WORD_W
) (
    output logic [OUT_W-1:0] out,
    input  logic [IN_W-1:0]  in,
    input  logic             signal,
    input  logic             clk,
    input  logic             reset,
    output logic [OUT_W-1:0] out_q,
    output logic             neg_q
);

    generate
        if (OUT_W <= IN_W) begin : g_bad_width
            $error("extend: OUT_W must be greater than IN_W");
        end
    endgenerate

    // AND rather than a mux so an unknown mode reaches only the upper bits.
    logic fill;

    always_comb begin
        fill = in[IN_W-1] & signal;
        out  = {{(OUT_W-IN_W){fill}}, in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            neg_q <= 1'b0;
        end else begin
            out_q <= out;
            neg_q <= fill;
        end
    end

endmodule : extend

// File: tb/tb_extend.sv
// Directed-vector bench for the immediate extender: combinational result,
// one-cycle registered copy, and reset clearing/resume behaviour.
module tb_extend;
    import extend_pkg::*;

    logic clk;
    logic reset;
    int unsigned checks;
    int unsigned errors;

    extend_if #(.IN_W(IMM_W), .OUT_W(WORD_W)) bus ();

    extend #(.IN_W(IMM_W), .OUT_W(WORD_W)) dut (
        .out    (bus.out),
        .in     (bus.in),
        .signal (bus.signal),
        .clk    (clk),
        .reset  (reset),
        .out_q  (bus.out_q),
        .neg_q  (bus.neg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] in;
        logic        sig;
        logic [31:0] exp_out;
        logic        exp_neg;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'h83FF, EXT_SIGN, 32'hFFFF83FF, 1'b1},
        '{16'h83FF, EXT_ZERO, 32'h000083FF, 1'b0},
        '{16'h03FF, EXT_SIGN, 32'h000003FF, 1'b0},
        '{16'h03FF, EXT_ZERO, 32'h000003FF, 1'b0},
        '{16'h8000, EXT_SIGN, 32'hFFFF8000, 1'b1},
        '{16'h7FFF, EXT_SIGN, 32'h00007FFF, 1'b0},
        '{16'hFFFF, EXT_ZERO, 32'h0000FFFF, 1'b0},
        '{16'hFFFF, EXT_SIGN, 32'hFFFFFFFF, 1'b1},
        '{16'h0000, EXT_SIGN, 32'h00000000, 1'b0}
    };

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.in = 16'hFFFF;
        bus.signal = EXT_SIGN;

        // Reset state, with the combinational path live during reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_q", bus.out_q, 32'h0);
        check("reset_neg_q", {31'b0, bus.neg_q}, 32'h0);
        check("reset_out_comb", bus.out, 32'hFFFFFFFF);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.in = vecs[i].in;
            bus.signal = vecs[i].sig;
            #1;
            check($sformatf("out[%0d]", i), bus.out, vecs[i].exp_out);
            @(posedge clk);
            #1;
            check($sformatf("out_q[%0d]", i), bus.out_q, vecs[i].exp_out);
            check($sformatf("neg_q[%0d]", i), {31'b0, bus.neg_q}, {31'b0, vecs[i].exp_neg});
        end

        // Load a nonzero negative value, then reset mid-stream.
        @(negedge clk);
        bus.in = 16'h83FF;
        bus.signal = EXT_SIGN;
        @(posedge clk);
        #1;
        check("pre_rst_out_q", bus.out_q, 32'hFFFF83FF);
        check("pre_rst_neg_q", {31'b0, bus.neg_q}, 32'h1);

        @(negedge clk);
        reset = 1'b1;
        bus.in = 16'h8000;
        #1;
        check("rst_out_comb", bus.out, 32'hFFFF8000);
        @(posedge clk);
        #1;
        check("rst_out_q", bus.out_q, 32'h0);
        check("rst_neg_q", {31'b0, bus.neg_q}, 32'h0);

        @(negedge clk);
        bus.in = 16'h7FFF;
        #1;
        check("rst_out_comb2", bus.out, 32'h00007FFF);
        @(posedge clk);
        #1;
        check("rst_hold_out_q", bus.out_q, 32'h0);

        // Release reset: capture resumes on the next edge.
        @(negedge clk);
        reset = 1'b0;
        bus.in = 16'hFFFF;
        bus.signal = EXT_SIGN;
        @(posedge clk);
        #1;
        check("resume_out_q", bus.out_q, 32'hFFFFFFFF);
        check("resume_neg_q", {31'b0, bus.neg_q}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_extend
